// File: rtl/trade_pkg.sv
// trade_pkg: shared FSM states, error codes, framing constants and record layout
package trade_pkg;
  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] MSG_LEN = 8'd8;
  typedef struct packed {
    logic [15:0] symbol;
    logic [31:0] price;
    logic [15:0] qty;
  } trade_rec_t;
endpackage

// File: rtl/trade_sat_counter.sv
// trade_sat_counter: statistics counter that sticks at its all-ones maximum
module trade_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/trade_msg_assembler.sv
// trade_msg_assembler: frames SOF/len/8-byte payload/XOR messages into a one-entry valid/ready slot.
// Define MSG_TIMEOUT_EN to abandon a frame after TIMEOUT_CYC consecutive idle cycles.
module trade_msg_assembler
  import trade_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         CNT_W       = 16,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      parsed_data_i,
  input  logic             packet_valid_i,
  output logic [15:0]      trade_symbol_o,
  output logic [31:0]      trade_price_o,
  output logic [15:0]      trade_qty_o,
  output logic             trade_valid_o,
  input  logic             trade_ready_i,
  output logic             err_pulse_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] frames_ok_o,
  output logic [CNT_W-1:0] frames_err_o,
  output logic [CNT_W-1:0] frames_drop_o
);
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [63:0] stage_q, stage_d;
  trade_rec_t  rec_q, rec_d;
  logic [1:0]  code_q, code_d;
  logic        valid_q, valid_d, pulse_q;
  logic        err_c, good_c, load_c, drop_c;
  logic [7:0]  byte_c;
  logic        unused_hi;
  assign byte_c = parsed_data_i[7:0];
  assign unused_hi = ^parsed_data_i[15:8];
`ifdef MSG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_c;
  assign tmo_c = !packet_valid_i && state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1);
  assign tmo_d = (packet_valid_i || state_q == IDLE || tmo_c) ? '0 : tmo_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYC > 0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    csum_d = csum_q;
    stage_d = stage_q;
    code_d = code_q;
    err_c = 1'b0;
    good_c = 1'b0;
    if (packet_valid_i) begin
      case (state_q)
        IDLE: state_d = (byte_c == SOF_BYTE) ? LEN : IDLE;
        LEN: begin
          state_d = (byte_c == MSG_LEN) ? PAYLOAD : IDLE;
          err_c = byte_c != MSG_LEN;
          code_d = err_c ? ERR_LEN : code_q;
          csum_d = byte_c;
          idx_d = '0;
        end
        PAYLOAD: begin
          stage_d = {stage_q[55:0], byte_c};
          csum_d = csum_q ^ byte_c;
          idx_d = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? CSUM : PAYLOAD;
        end
        default: begin
          state_d = IDLE;
          good_c = byte_c == csum_q;
          err_c = !good_c;
          code_d = good_c ? code_q : ERR_CSUM;
        end
      endcase
    end
`ifdef MSG_TIMEOUT_EN
    if (tmo_c) begin
      state_d = IDLE;
      err_c = 1'b1;
      code_d = ERR_TIMEOUT;
    end
`endif
  end
  // a completing frame may load the slot in the same cycle the consumer drains it
  assign load_c = good_c && (!valid_q || trade_ready_i);
  assign drop_c = good_c && valid_q && !trade_ready_i;
  assign valid_d = load_c || (valid_q && !trade_ready_i);
  assign rec_d = load_c ? trade_rec_t'(stage_q) : rec_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      csum_q <= '0;
      stage_q <= '0;
      rec_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      stage_q <= stage_d;
      rec_q <= rec_d;
      code_q <= code_d;
      valid_q <= valid_d;
      pulse_q <= err_c;
    end
  end
  assign trade_symbol_o = rec_q.symbol;
  assign trade_price_o = rec_q.price;
  assign trade_qty_o = rec_q.qty;
  assign trade_valid_o = valid_q;
  assign err_pulse_o = pulse_q;
  assign err_code_o = code_q;
  trade_sat_counter #(.W(CNT_W)) u_ok   (.clk(clk), .rst(rst), .inc_i(load_c), .cnt_o(frames_ok_o));
  trade_sat_counter #(.W(CNT_W)) u_err  (.clk(clk), .rst(rst), .inc_i(err_c),  .cnt_o(frames_err_o));
  trade_sat_counter #(.W(CNT_W)) u_drop (.clk(clk), .rst(rst), .inc_i(drop_c), .cnt_o(frames_drop_o));
endmodule

// File: tb/tb_trade_msg_assembler.sv
// tb_trade_msg_assembler: vector table, directed corner sequences and random frames vs a byte-queue model
module tb_trade_msg_assembler;
  localparam int TMO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] pd = '0;
  logic pv = 1'b0, rdy = 1'b0;
  logic [15:0] sym, qty, s_sym, s_qty;
  logic [31:0] price, s_price;
  logic tv, ep, s_tv, s_ep;
  logic [1:0] ec, s_ec;
  logic [15:0] f_ok, f_err, f_drop;
  logic [1:0] s_ok, s_err, s_drop;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  trade_msg_assembler #(.CNT_W(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .parsed_data_i(pd), .packet_valid_i(pv),
    .trade_symbol_o(sym), .trade_price_o(price), .trade_qty_o(qty),
    .trade_valid_o(tv), .trade_ready_i(rdy), .err_pulse_o(ep), .err_code_o(ec),
    .frames_ok_o(f_ok), .frames_err_o(f_err), .frames_drop_o(f_drop));

  trade_msg_assembler #(.CNT_W(2), .TIMEOUT_CYC(TMO)) dut_sat (
    .clk(clk), .rst(rst), .parsed_data_i(pd), .packet_valid_i(pv),
    .trade_symbol_o(s_sym), .trade_price_o(s_price), .trade_qty_o(s_qty),
    .trade_valid_o(s_tv), .trade_ready_i(rdy), .err_pulse_o(s_ep), .err_code_o(s_ec),
    .frames_ok_o(s_ok), .frames_err_o(s_err), .frames_drop_o(s_drop));

  // reference model: bytes of the open frame, output slot and plain integer counters
  logic [7:0] mq[$];
  int m_ok, m_err, m_drop, gap;
  bit m_tv, m_ep;
  logic [1:0] m_ec;
  logic [63:0] m_rec;

  typedef struct {
    bit v;
    logic [7:0] b;
    bit r;
    bit tv;
    bit ep;
    logic [1:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x, input int w);
    return x > (1 << w) - 1 ? (1 << w) - 1 : x;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ok = 0; m_err = 0; m_drop = 0; gap = 0;
    m_tv = 0; m_ep = 0; m_ec = 0; m_rec = 0;
  endtask

  task automatic model(input bit v, input logic [7:0] b, input bit r);
    bit good, err;
    logic [1:0] code;
    logic [7:0] x;
    logic [63:0] rec;
    good = 0; err = 0; code = 0; rec = 0;
    if (v) begin
      gap = 0;
      if (mq.size() == 0) begin
        if (b == 8'hA5) mq.push_back(b);
      end else begin
        mq.push_back(b);
        if (mq.size() == 2 && b != 8'd8) begin
          err = 1; code = 1; mq.delete();
        end else if (mq.size() == 11) begin
          x = 0;
          for (int i = 1; i < 10; i++) x ^= mq[i];
          rec = {mq[2], mq[3], mq[4], mq[5], mq[6], mq[7], mq[8], mq[9]};
          if (x == b) good = 1;
          else begin err = 1; code = 2; end
          mq.delete();
        end
      end
    end else if (mq.size() != 0) begin
      gap++;
`ifdef MSG_TIMEOUT_EN
      if (gap == TMO) begin err = 1; code = 3; mq.delete(); gap = 0; end
`endif
    end else gap = 0;
    if (good && (!m_tv || r)) begin
      m_rec = rec; m_tv = 1; m_ok++;
    end else begin
      if (good) m_drop++;
      if (m_tv && r) m_tv = 0;
    end
    if (err) begin m_err++; m_ec = code; end
    m_ep = err;
  endtask

  task automatic compare_all();
    chk("trade_valid", 64'(tv), 64'(m_tv));
    chk("err_pulse", 64'(ep), 64'(m_ep));
    chk("err_code", 64'(ec), 64'(m_ec));
    chk("symbol", 64'(sym), 64'(m_rec[63:48]));
    chk("price", 64'(price), 64'(m_rec[47:16]));
    chk("qty", 64'(qty), 64'(m_rec[15:0]));
    chk("frames_ok", 64'(f_ok), 64'(sat(m_ok, 16)));
    chk("frames_err", 64'(f_err), 64'(sat(m_err, 16)));
    chk("frames_drop", 64'(f_drop), 64'(sat(m_drop, 16)));
    chk("sat_ok", 64'(s_ok), 64'(sat(m_ok, 2)));
    chk("sat_err", 64'(s_err), 64'(sat(m_err, 2)));
    chk("sat_drop", 64'(s_drop), 64'(sat(m_drop, 2)));
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit r);
    pv = v; pd = {8'($urandom), b}; rdy = r;
    @(posedge clk);
    model(v, b, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = 1'b0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    compare_all();
  endtask

  function automatic bit pick_r(input int mode);
    return mode == 2 ? ($urandom % 4 != 0) : bit'(mode);
  endfunction

  // rmode/lmode: 0 = ready low, 1 = ready high, 2 = random; lmode applies to the checksum byte
  task automatic send_frame(input logic [15:0] fs, input logic [31:0] fp, input logic [15:0] fq,
                            input logic [7:0] lenb, input bit bad, input int gap_at,
                            input int gap_len, input int rmode, input int lmode);
    logic [7:0] f[11];
    f[0] = 8'hA5; f[1] = lenb;
    f[2] = fs[15:8]; f[3] = fs[7:0];
    f[4] = fp[31:24]; f[5] = fp[23:16]; f[6] = fp[15:8]; f[7] = fp[7:0];
    f[8] = fq[15:8]; f[9] = fq[7:0];
    f[10] = 8'd8;
    for (int i = 2; i < 10; i++) f[10] ^= f[i];
    if (bad) f[10] ^= 8'h01;
    for (int i = 0; i < 11; i++) begin
      if (i == gap_at) for (int g = 0; g < gap_len; g++) step(0, 8'h00, pick_r(rmode));
      step(1, f[i], i == 10 ? pick_r(lmode) : pick_r(rmode));
    end
  endtask

  task automatic add(input bit v, input logic [7:0] b, input bit r, input bit etv,
                     input bit eep, input logic [1:0] eec);
    vec_t t;
    t.v = v; t.b = b; t.r = r; t.tv = etv; t.ep = eep; t.ec = eec;
    tbl.push_back(t);
  endtask

  initial begin
    logic [7:0] gf[11];
    gf = '{8'hA5, 8'h08, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h27, 8'h10, 8'h00, 8'h64, 8'h71};
    for (int i = 0; i < 10; i++) add(1, gf[i], 1, 0, 0, 2'd0);
    add(1, 8'h71, 1, 1, 0, 2'd0);
    add(0, 8'h00, 1, 0, 0, 2'd0);
    for (int i = 0; i < 10; i++) add(1, gf[i], 1, 0, 0, 2'd0);
    add(1, 8'h70, 1, 0, 1, 2'd2);
    add(0, 8'h00, 1, 0, 0, 2'd2);
    add(1, 8'hA5, 1, 0, 0, 2'd2);
    add(1, 8'h07, 1, 0, 1, 2'd1);
    add(1, 8'h11, 1, 0, 0, 2'd1);
    add(1, 8'h22, 1, 0, 0, 2'd1);
    for (int i = 0; i < 10; i++) add(1, gf[i], 1, 0, 0, 2'd1);
    add(1, 8'h71, 1, 1, 0, 2'd1);
    add(0, 8'h00, 1, 0, 0, 2'd1);

    model_clear();
    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), 64'(tv), 64'(tbl[i].tv));
      chk($sformatf("tbl%0d_pulse", i), 64'(ep), 64'(tbl[i].ep));
      chk($sformatf("tbl%0d_code", i), 64'(ec), 64'(tbl[i].ec));
    end
    chk("tbl_ok", 64'(f_ok), 64'd2);
    chk("tbl_err", 64'(f_err), 64'd2);

    // backpressure: hold first record, drop second, third loads with a same-cycle handshake
    do_reset();
    send_frame(16'h1111, 32'h01020304, 16'h0A0B, 8'd8, 0, 0, 0, 0, 0);
    chk("bp_first_valid", 64'(tv), 64'd1);
    send_frame(16'h2222, 32'h05060708, 16'h0C0D, 8'd8, 0, 0, 0, 0, 0);
    chk("bp_held_symbol", 64'(sym), 64'h1111);
    chk("bp_held_price", 64'(price), 64'h01020304);
    chk("bp_drop", 64'(f_drop), 64'd1);
    send_frame(16'h3333, 32'h090A0B0C, 16'h0E0F, 8'd8, 0, 0, 0, 0, 1);
    chk("bp_third_valid", 64'(tv), 64'd1);
    chk("bp_third_symbol", 64'(sym), 64'h3333);
    chk("bp_ok", 64'(f_ok), 64'd2);
    step(0, 8'h00, 1);
    chk("bp_drained", 64'(tv), 64'd0);

    // gaps mid-frame
    do_reset();
    send_frame(16'h0042, 32'hDEADBEEF, 16'h1234, 8'd8, 0, 5, 3, 1, 1);
    chk("gap3_valid", 64'(tv), 64'd1);
    chk("gap3_price", 64'(price), 64'hDEADBEEF);
`ifdef MSG_TIMEOUT_EN
    step(1, 8'hA5, 1); step(1, 8'h08, 1); step(1, 8'h00, 1);
    for (int g = 0; g < TMO; g++) step(0, 8'h00, 1);
    chk("tmo_pulse", 64'(ep), 64'd1);
    chk("tmo_code", 64'(ec), 64'd3);
    send_frame(16'h0077, 32'h00000001, 16'h0002, 8'd8, 0, 0, 0, 1, 1);
    chk("tmo_recover_symbol", 64'(sym), 64'h0077);
    chk("tmo_recover_valid", 64'(tv), 64'd1);
`else
    send_frame(16'h0055, 32'h00000003, 16'h0004, 8'd8, 0, 4, 20, 1, 1);
    chk("nogap_tmo_code", 64'(ec), 64'd0);
    chk("nogap_tmo_symbol", 64'(sym), 64'h0055);
`endif

    // reset mid-frame, then saturation of the narrow counters
    do_reset();
    for (int i = 0; i < 5; i++) step(1, gf[i], 1);
    do_reset();
    send_frame(16'h002A, 32'h00002710, 16'h0064, 8'd8, 0, 0, 0, 1, 1);
    chk("rst_ok", 64'(f_ok), 64'd1);
    chk("rst_valid", 64'(tv), 64'd1);
    step(0, 8'h00, 1);
    chk("rst_ok_once", 64'(f_ok), 64'd1);
    for (int k = 0; k < 4; k++) send_frame(16'(k), 32'(k * 3), 16'(k + 9), 8'd8, 0, 0, 0, 1, 1);
    chk("sat_ok_full", 64'(f_ok), 64'd5);
    chk("sat_ok_narrow", 64'(s_ok), 64'd3);

    // random frames, junk and corruptions with random ready and gaps
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int kind, gl;
      kind = $urandom % 10;
      gl = ($urandom % 6 == 0) ? $urandom_range(1, 6) : 0;
      if (kind == 0) step(1, 8'($urandom), pick_r(2));
      else send_frame(16'($urandom), $urandom, 16'($urandom),
                      kind == 1 ? 8'($urandom_range(0, 7)) : 8'd8, kind == 2,
                      $urandom_range(1, 10), gl, 2, 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
